multiword_adder_sequencer: RTL

Sequences one internal fast_adder instance (word width bit_width) across word_count words to perform a word_count*bit_width add or subtract. One word is processed per cycle, with the carry registered between words. The block sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It is the multi-precision arithmetic controller for the utils adder datapath.

---
 rtl/multiword_adder_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multiword_adder_sequencer.sv
// Multi-precision add/subtract: one fast_adder word per cycle, carry
// held in a register between words, valid/ready on both sides.
//
// fast_adder ports:
//   a, b, c_in      word operands and carry-in
//   sum, c_out      word result and carry-out
//   p_out, g_out    word-level propagate / generate
//
// multiword_adder_sequencer ports:
//   CLK, RST                  clock, synchronous active-high reset
//   IN_VALID, IN_READY        operand handshake (IN_READY = IDLE)
//   SUB, C_IN, A, B           operation select, carry-in, operands
//   OUT_VALID, OUT_READY      result handshake
//   R, C_OUT, OVERFLOW        result, top carry, signed overflow

module fast_adder #(
    parameter int cascade_size = 4,
    parameter int bit_width    = 8
) (
    input  logic [bit_width-1:0] a,
    input  logic [bit_width-1:0] b,
    input  logic                 c_in,
    output logic [bit_width-1:0] sum,
    output logic                 c_out,
    output logic                 p_out,
    output logic                 g_out
);

    logic [bit_width-1:0] p;
    logic [bit_width-1:0] g;
    logic [bit_width:0]   carry;

    assign p = a ^ b;
    assign g = a & b;

    // Each bit's carry is formed from its group's carry-in plus the
    // group-local generate/propagate prefix, so the ripple path is one
    // step per cascade_size bits rather than one per bit.
    always_comb begin
        logic gg;
        logic pp;
        logic gw;
        carry    = '0;
        carry[0] = c_in;
        gw       = 1'b0;
        for (int s = 0; s < bit_width; s += cascade_size) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = s; j < s + cascade_size && j < bit_width; j++) begin
                gg = g[j] | (p[j] & gg);
                pp = pp & p[j];
                carry[j+1] = gg | (pp & carry[s]);
            end
        end
        for (int k = 0; k < bit_width; k++) begin
            gw = g[k] | (p[k] & gw);
        end
        g_out = gw;
    end

    assign sum   = p ^ carry[bit_width-1:0];
    assign c_out = carry[bit_width];
    assign p_out = &p;

endmodule

module multiword_adder_sequencer #(
    parameter int cascade_size = 4,
    parameter int bit_width    = 8,
    parameter int word_count   = 4,
    localparam int W           = word_count * bit_width,
    localparam int IW          = (word_count > 1) ? $clog2(word_count) : 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic         SUB,
    input  logic         C_IN,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] R,
    output logic         C_OUT,
    output logic         OVERFLOW
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(word_count - 1);

    state_t state;
    logic [IW-1:0] idx;
    logic          carry_q;

    logic [word_count-1:0][bit_width-1:0] a_q;
    logic [word_count-1:0][bit_width-1:0] bx_q;
    logic [word_count-1:0][bit_width-1:0] r_q;

    logic [bit_width-1:0] a_word;
    logic [bit_width-1:0] b_word;
    logic [bit_width-1:0] sum;
    logic                 c_next;
    logic                 ov_next;

    assign a_word = a_q[idx];
    assign b_word = bx_q[idx];

    // Word-level P/G are not needed: carry crosses words via carry_q.
    fast_adder #(
        .cascade_size(cascade_size),
        .bit_width   (bit_width)
    ) u_add (
        .a    (a_word),
        .b    (b_word),
        .c_in (carry_q),
        .sum  (sum),
        .c_out(c_next),
        .p_out(),
        .g_out()
    );

    // Only meaningful on the last word, where idx selects the top word.
    assign ov_next = (a_q[word_count-1][bit_width-1] ==
                      bx_q[word_count-1][bit_width-1]) &&
                     (sum[bit_width-1] != a_q[word_count-1][bit_width-1]);

    assign IN_READY = (state == IDLE);
    assign R        = r_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            bx_q      <= '0;
            r_q       <= '0;
            C_OUT     <= 1'b0;
            OVERFLOW  <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q     <= A;
                        bx_q    <= SUB ? ~B : B;
                        carry_q <= SUB ? 1'b1 : C_IN;
                        idx     <= '0;
                        r_q     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    r_q[idx] <= sum;
                    carry_q  <= c_next;
                    if (idx == LAST) begin
                        C_OUT     <= c_next;
                        OVERFLOW  <= ov_next;
                        OUT_VALID <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
